demux_n_stream: RTL and testbench

- Parametrised, registered 1-to-NUM_CH demultiplexer with a valid/ready handshake on every channel.
- Successor to the combinational 8-way DEMUX: generalised in data width and channel count.
- Each output channel holds its last data in a one-entry register until that data is consumed.
- Sits between board inputs (switches or upstream logic) and per-channel consumers (LED drivers, downstream FSMs).

---
 rtl/demux_n_stream.sv | 89 ++++++++
 tb/tb_demux_n_stream.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_n_stream.sv
// Registered 1-to-NUM_CH stream demultiplexer with a one-entry holding register per channel.
// Optional round-robin scan select is enabled with the DEMUX_N_SCAN_EN macro.
module demux_n_stream #(
  parameter int DATA_W = 1,
  parameter int SEL_W  = 3,
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef DEMUX_N_SCAN_EN
  input  logic                     scan_en,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     err_sel,
  output logic [CNT_W-1:0]         xfer_cnt
);

  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

  logic [SEL_W-1:0]  esel;
  logic [NUM_CH-1:0] sel_hit;
  logic              in_range;
  logic              accept;

`ifdef DEMUX_N_SCAN_EN
  logic [SEL_W-1:0] scan_ptr;

  assign esel = scan_en ? scan_ptr : in_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr <= '0;
    end else if (accept && scan_en) begin
      scan_ptr <= (scan_ptr == SEL_W'(NUM_CH-1)) ? '0 : scan_ptr + 1'b1;
    end
  end
`else
  assign esel = in_sel;
`endif

  // One-hot decode of the effective select; out-of-range selects leave it all zero.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_hit[k] = (esel == SEL_W'(k));
    end
  end

  assign in_range = ({1'b0, esel} < NUM_CH_L);
  assign in_ready = !in_range || (|(sel_hit & (~out_valid | out_ready)));
  assign accept   = in_valid && in_ready;

  // An accept to a channel wins over its drain, so a full channel can take a word every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (accept && sel_hit[k]) begin
          out_data[k*DATA_W +: DATA_W] <= in_data;
          out_valid[k]                 <= 1'b1;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      err_sel <= accept && !in_range;
      if (accept && in_range) begin
        xfer_cnt <= xfer_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_n_stream.sv
// Self-checking bench for demux_n_stream (6 channels on a 3-bit select, 4-bit counter).
// Scan-mode steps are included when DEMUX_N_SCAN_EN is defined.
module tb_demux_n_stream;

  localparam int DATA_W = 4;
  localparam int SEL_W  = 3;
  localparam int NUM_CH = 6;
  localparam int CNT_W  = 4;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     err_sel;
  logic [CNT_W-1:0]         xfer_cnt;
  logic                     scan_en;

  int checks   = 0;
  int failures = 0;

  // Reference model of the observable state
  bit              m_valid [NUM_CH];
  logic [DATA_W-1:0] m_data [NUM_CH];
  bit              m_err;
  int              m_cnt;
  int              m_ptr;

  demux_n_stream #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef DEMUX_N_SCAN_EN
    .scan_en  (scan_en),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err_sel  (err_sel),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
    end
    m_err = 1'b0;
    m_cnt = 0;
    m_ptr = 0;
  endtask

  task automatic checkState(input string tag);
    logic [NUM_CH-1:0]        ev;
    logic [NUM_CH*DATA_W-1:0] ed;
    for (int k = 0; k < NUM_CH; k++) begin
      ev[k]                  = m_valid[k];
      ed[k*DATA_W +: DATA_W] = m_data[k];
    end
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    checkOutput({tag, ".out_data"},  64'(out_data),  64'(ed));
    checkOutput({tag, ".err_sel"},   64'(err_sel),   64'(m_err));
    checkOutput({tag, ".xfer_cnt"},  64'(xfer_cnt),  64'(m_cnt));
  endtask

  // Drive one cycle of inputs, check in_ready, advance the model and check the registered outputs.
  task automatic applyStimulus(input string tag, input bit v, input int sel,
                               input logic [DATA_W-1:0] d, input logic [NUM_CH-1:0] rdy);
    int esel;
    bit exp_rdy;
    bit acc;
    in_valid  = v;
    in_sel    = SEL_W'(sel);
    in_data   = d;
    out_ready = rdy;
    #1;
    esel = scan_en ? m_ptr : sel;
    if (esel >= NUM_CH) exp_rdy = 1'b1;
    else                exp_rdy = !m_valid[esel] || rdy[esel];
    checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    acc   = v && exp_rdy;
    m_err = acc && (esel >= NUM_CH);
    for (int k = 0; k < NUM_CH; k++) begin
      if (acc && esel == k) begin
        m_data[k]  = d;
        m_valid[k] = 1'b1;
      end else if (rdy[k]) begin
        m_valid[k] = 1'b0;
      end
    end
    if (acc && esel < NUM_CH) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (acc && scan_en)       m_ptr = (m_ptr + 1) % NUM_CH;
    @(posedge clk);
    #1;
    checkState(tag);
  endtask

  initial begin
    scan_en   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = '1;
    rst_n     = 1'b1;
    modelReset();
    #1 rst_n = 1'b0;
    #1;
    checkState("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset released");

    for (int s = 0; s < 8; s++) applyStimulus("idle", 1'b0, s, '0, '1);

    applyStimulus("sel5_first",  1'b1, 5, 4'h1, '0);
    checkOutput("sel5_valid", 64'(out_valid), 64'h20);
    applyStimulus("sel5_blocked", 1'b1, 5, 4'h2, '0);
    checkOutput("sel5_data_held", 64'(out_data[5*DATA_W +: DATA_W]), 64'h1);
    applyStimulus("sel2", 1'b1, 2, 4'h3, '0);
    checkOutput("sel2_valid", 64'(out_valid), 64'h24);
    checkOutput("sel2_cnt", 64'(xfer_cnt), 64'd2);

    applyStimulus("drain_all", 1'b0, 0, '0, '1);
    applyStimulus("ch3_fill", 1'b1, 3, 4'h9, '0);
    applyStimulus("ch3_tp0",  1'b1, 3, 4'h0, 6'h08);
    checkOutput("ch3_tp0_data", 64'(out_data[3*DATA_W +: DATA_W]), 64'h0);
    applyStimulus("ch3_tp1",  1'b1, 3, 4'h1, 6'h08);
    checkOutput("ch3_tp1_data", 64'(out_data[3*DATA_W +: DATA_W]), 64'h1);
    checkOutput("ch3_tp1_valid", 64'(out_valid[3]), 64'h1);

    applyStimulus("oor7", 1'b1, 7, 4'h5, '0);
    checkOutput("oor7_err", 64'(err_sel), 64'h1);
    applyStimulus("oor_idle", 1'b0, 0, '0, '0);
    checkOutput("oor_err_clear", 64'(err_sel), 64'h0);
    applyStimulus("oor6", 1'b1, 6, 4'hA, '0);
    applyStimulus("oor6_idle", 1'b0, 0, '0, '0);

    // Reset in the middle of a transfer, checked before any clock edge
    in_valid  = 1'b1;
    in_sel    = 3'd1;
    in_data   = 4'h7;
    out_ready = '0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkState("midreset");
    checkOutput("midreset.in_ready", 64'(in_ready), 64'h1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkState("post_reset");

    for (int i = 0; i < 17; i++) applyStimulus("wrap", 1'b1, i % NUM_CH, 4'(i), '1);
    checkOutput("wrap_cnt", 64'(xfer_cnt), 64'd1);

`ifdef DEMUX_N_SCAN_EN
    applyStimulus("scan_drain", 1'b0, 0, '0, '1);
    scan_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus("scan", 1'b1, 0, 4'(i + 3), '1);
      checkOutput("scan_channel", 64'(out_valid), 64'(1 << (i % NUM_CH)));
    end
    scan_en = 1'b0;
    applyStimulus("scan_off", 1'b1, 4, 4'hC, '1);
    checkOutput("scan_off_channel", 64'(out_valid), 64'h10);
`endif

    for (int i = 0; i < 120; i++) begin
`ifdef DEMUX_N_SCAN_EN
      scan_en = ($urandom_range(0, 3) == 0);
`endif
      applyStimulus("random", $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                    DATA_W'($urandom), NUM_CH'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
